// File: rtl/ram_equ_pingpong.sv
// Double-buffered subcarrier RAM for the NB-IoT uplink equaliser.
// The estimator fills one bank while the equaliser reads the other bank.
// A small occupancy FSM tracks how many banks are complete and drives the
// ready flags. A sticky error flag records protocol violations.
module ram_equ_pingpong #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH,
    parameter int unsigned DEPTH             = 12,
    parameter int unsigned ADDR_WIDTH        = $clog2(DEPTH)
) (
    input  logic                         i_clk_ram,
    input  logic                         i_rst_ram,
    input  logic                         i_wr_en_ram,
    input  logic [ADDR_WIDTH-1:0]        i_wr_add_ram,
    input  logic [DOUBLE_DATA_WIDTH-1:0] i_data_ram,
    input  logic                         i_wr_last_ram,
    input  logic                         i_rd_en_ram,
    input  logic [ADDR_WIDTH-1:0]        i_rd_add_ram,
    input  logic                         i_rd_release_ram,
    output logic [DOUBLE_DATA_WIDTH-1:0] o_data_ram,
    output logic                         o_valid_ram,
    output logic                         o_wr_ready_ram,
    output logic                         o_rd_ready_ram,
    output logic                         o_err_ram
);

    localparam int unsigned MEM_WORDS = 2 * DEPTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_BOTH  = 2'd2
    } occ_t;

    occ_t                         occ_q;
    occ_t                         occ_d;
    logic                         wr_bank_q;
    logic                         wr_bank_d;
    logic                         rd_bank_q;
    logic                         rd_bank_d;
    logic                         err_d;
    logic                         wr_ready_d;
    logic                         rd_ready_d;
    logic                         wr_addr_ok;
    logic                         rd_addr_ok;
    logic                         wr_acc;
    logic                         rd_acc;
    logic                         last_acc;
    logic                         rel_acc;
    logic [MEM_AW-1:0]            wr_idx;
    logic [MEM_AW-1:0]            rd_idx;
    logic [DOUBLE_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Acceptance qualifiers; ready flags are registered so no input reaches them combinationally
    assign wr_addr_ok = (32'(i_wr_add_ram) < DEPTH);
    assign rd_addr_ok = (32'(i_rd_add_ram) < DEPTH);
    assign wr_acc     = i_wr_en_ram && o_wr_ready_ram && wr_addr_ok;
    assign rd_acc     = i_rd_en_ram && o_rd_ready_ram;
    assign last_acc   = wr_acc && i_wr_last_ram;
    assign rel_acc    = i_rd_release_ram && (occ_q != OCC_EMPTY);

    // Flat memory index: bank 1 sits directly above bank 0
    assign wr_idx = MEM_AW'(i_wr_add_ram) + (wr_bank_q ? MEM_AW'(DEPTH) : MEM_AW'(0));
    assign rd_idx = MEM_AW'(i_rd_add_ram) + (rd_bank_q ? MEM_AW'(DEPTH) : MEM_AW'(0));

    // State register: occupancy, bank pointers, ready flags and sticky error
    always_ff @(posedge i_clk_ram or posedge i_rst_ram) begin
        if (i_rst_ram) begin
            occ_q          <= OCC_EMPTY;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            o_wr_ready_ram <= 1'b1;
            o_rd_ready_ram <= 1'b0;
            o_err_ram      <= 1'b0;
        end else begin
            occ_q          <= occ_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            o_wr_ready_ram <= wr_ready_d;
            o_rd_ready_ram <= rd_ready_d;
            o_err_ram      <= err_d;
        end
    end

    // Next-state logic: occupancy moves on completed writes and releases
    always_comb begin
        occ_d     = occ_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = o_err_ram;

        if (last_acc) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (rel_acc) begin
            rd_bank_d = ~rd_bank_q;
        end

        case (occ_q)
            OCC_EMPTY: begin
                if (last_acc) begin
                    occ_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (last_acc && !rel_acc) begin
                    occ_d = OCC_BOTH;
                end else if (!last_acc && rel_acc) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_BOTH: begin
                if (rel_acc) begin
                    occ_d = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase

        if ((i_wr_en_ram && (!o_wr_ready_ram || !wr_addr_ok)) ||
            (i_rd_en_ram && (!o_rd_ready_ram || !rd_addr_ok)) ||
            (i_rd_release_ram && (occ_q == OCC_EMPTY))) begin
            err_d = 1'b1;
        end
    end

    // Output decode: ready flags derived from the next occupancy, registered above
    always_comb begin
        wr_ready_d = (occ_d != OCC_BOTH);
        rd_ready_d = (occ_d != OCC_EMPTY);
    end

    // Memory write port; contents are intentionally not reset
    always_ff @(posedge i_clk_ram) begin
        if (wr_acc) begin
            mem[wr_idx] <= i_data_ram;
        end
    end

    // Registered read port; out-of-range reads return zero
    always_ff @(posedge i_clk_ram or posedge i_rst_ram) begin
        if (i_rst_ram) begin
            o_data_ram  <= '0;
            o_valid_ram <= 1'b0;
        end else begin
            o_valid_ram <= rd_acc;
            if (rd_acc) begin
                o_data_ram <= rd_addr_ok ? mem[rd_idx] : '0;
            end
        end
    end

endmodule
